// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder.
//   feeder_state_t : job sequencing states
//   FLUSH_CYC(n)   : zero-flush length so the last operand reaches PE(n-1,n-1)
//   DRAIN_CYC(n)   : number of result rows drained from the bottom edge
//   lane_t         : one operand lane at the default data width
package systolic_feeder_pkg;

   localparam int unsigned DEF_N  = 4;
   localparam int unsigned DEF_DW = 8;

   typedef logic [DEF_DW-1:0] lane_t;

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} feeder_state_t;

   // skew (n-1) + array width (n-1) + accumulate (1)
   function automatic int unsigned FLUSH_CYC(input int unsigned n);
      return 2 * n - 1;
   endfunction

   function automatic int unsigned DRAIN_CYC(input int unsigned n);
      return n;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one feeder lane.
//   clk, reset (async, active-low clear)
//   d : lane input, shifted in every cycle
//   q : lane output, DEPTH cycles after d is captured
module skew_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Left/top edge feeder of an NxN output-stationary PE array.
// Accepts one column per beat, skews lane i by i cycles, and sequences
// the array through clear -> stream -> zero flush -> result drain.
//   clk, reset      : clock, async active-low reset
//   in_valid/ready  : column beat handshake (in_ready decodes from state)
//   in_data         : N lanes of DW bits, lane i -> array row i
//   in_last         : final beat of the job
//   left_out        : skewed lanes into PE column 0
//   pe_clear        : clear PE accumulators (high while idle)
//   pe_through      : PE drain mode
//   drain_valid     : bottom-row down_out carries a result
//   busy            : job in progress
//   done            : pulse on the last drain cycle
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int unsigned N  = DEF_N,
   parameter int unsigned DW = DEF_DW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic            in_last,
   output logic [N*DW-1:0] left_out,
   output logic            pe_clear,
   output logic            pe_through,
   output logic            drain_valid,
   output logic            busy,
   output logic            done
);

   localparam int unsigned CW = $clog2(2 * N) + 1;

   feeder_state_t state, next_state;
   logic [CW-1:0] flush_cnt, drain_cnt, flush_cnt_nxt, drain_cnt_nxt;
   logic          accept;
   logic          clear_nxt, through_nxt, busy_nxt, done_nxt;

   assign in_ready = (state == IDLE) || (state == STREAM);
   assign accept   = in_valid && in_ready;

   // State register; control outputs are registered from next-state values
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         flush_cnt   <= '0;
         drain_cnt   <= '0;
         pe_clear    <= 1'b1;
         pe_through  <= 1'b0;
         drain_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= next_state;
         flush_cnt   <= flush_cnt_nxt;
         drain_cnt   <= drain_cnt_nxt;
         pe_clear    <= clear_nxt;
         pe_through  <= through_nxt;
         drain_valid <= through_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
      end
   end

   // Next-state and counter logic
   always_comb begin
      next_state    = state;
      flush_cnt_nxt = flush_cnt;
      drain_cnt_nxt = drain_cnt;
      unique case (state)
         IDLE, STREAM: begin
            if (accept && in_last) begin
               next_state    = FLUSH;
               flush_cnt_nxt = CW'(FLUSH_CYC(N));
            end else if (accept) begin
               next_state = STREAM;
            end
         end
         FLUSH: begin
            flush_cnt_nxt = flush_cnt - 1'b1;
            if (flush_cnt == CW'(1)) begin
               next_state    = DRAIN;
               drain_cnt_nxt = CW'(DRAIN_CYC(N));
            end
         end
         DRAIN: begin
            drain_cnt_nxt = drain_cnt - 1'b1;
            if (drain_cnt == CW'(1)) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode, one cycle ahead of the registered outputs
   always_comb begin
      clear_nxt   = (next_state == IDLE);
      through_nxt = (next_state == DRAIN);
      busy_nxt    = (next_state != IDLE);
      done_nxt    = (next_state == DRAIN) && (drain_cnt_nxt == CW'(1));
   end

   // Chains shift every cycle: outside STREAM/FLUSH they only see zeros and
   // are already empty (flush is longer than the deepest lane), so this is
   // equivalent to gating the shift on state.
   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_delay_line #(
         .DEPTH (i + 1),
         .DW    (DW)
      ) u_skew (
         .clk   (clk),
         .reset (reset),
         .d     (accept ? in_data[i*DW +: DW] : '0),
         .q     (left_out[i*DW +: DW])
      );
   end

endmodule
